// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: SPI/QSPI RAM device end, oversampled in the clk domain,
// serving 0x03/0x02 (and quad 0xEB/0x38) from an on-chip byte array.
// Build option: define QSPI_QUAD_EN to add the quad commands 0xEB and 0x38.
module qspi_ram_responder #(
   parameter int unsigned MEM_BYTES        = 4096,
   parameter int unsigned QUAD_WAIT_CYCLES = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         spi_cs_n,
   input  logic                         spi_sclk,
   input  logic [3:0]                   spi_io_in,
   output logic [3:0]                   spi_io_out,
   output logic [3:0]                   spi_io_oe,
   output logic                         busy,
   output logic                         err_cmd,
   input  logic                         init_we,
   input  logic [$clog2(MEM_BYTES)-1:0] init_addr,
   input  logic [7:0]                   init_data
);

   localparam int unsigned AW = $clog2(MEM_BYTES);
   localparam int unsigned CW = 5;
`ifdef QSPI_QUAD_EN
   localparam int unsigned IOW = 4;
`else
   localparam int unsigned IOW = 1;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
   } state_t;

   logic           cs_m_q, cs_s_q, sclk_m_q, sclk_s_q, sclk_p_q;
   logic [IOW-1:0] io_m_q, io_s_q;
   logic           rise_c, fall_c;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [7:0]     sr_q, sr_d;
   logic [7:0]     out_sr_q, out_sr_d;
   logic [AW-1:0]  ptr_q, ptr_d;
   logic           rd_q, rd_d;
   logic           fetch_q, fetch_d;
   logic           commit_q, commit_d;
   logic [AW-1:0]  caddr_q, caddr_d;
   logic [7:0]     cdata_q, cdata_d;
   logic [3:0]     io_out_q, io_out_d, oe_q, oe_d;
   logic           busy_q, busy_d, err_q, err_d;
   logic [CW-1:0]  addr_last_c, byte_last_c;
   logic [7:0]     cmd_byte_c;
`ifdef QSPI_QUAD_EN
   logic           quad_q, quad_d;
`else
   logic           unused_io_c;
   assign unused_io_c = ^spi_io_in[3:1];
`endif

   logic [7:0] mem [MEM_BYTES];

   // Two-flop synchronizers plus SCLK history for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_m_q   <= 1'b1;
         cs_s_q   <= 1'b1;
         sclk_m_q <= 1'b0;
         sclk_s_q <= 1'b0;
         sclk_p_q <= 1'b0;
         io_m_q   <= '0;
         io_s_q   <= '0;
      end else begin
         cs_m_q   <= spi_cs_n;
         cs_s_q   <= cs_m_q;
         sclk_m_q <= spi_sclk;
         sclk_s_q <= sclk_m_q;
         sclk_p_q <= sclk_s_q;
         io_m_q   <= spi_io_in[IOW-1:0];
         io_s_q   <= io_m_q;
      end
   end

   assign rise_c = sclk_s_q & ~sclk_p_q;
   assign fall_c = ~sclk_s_q & sclk_p_q;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sr_q     <= '0;
         out_sr_q <= '0;
         ptr_q    <= '0;
         rd_q     <= 1'b0;
         fetch_q  <= 1'b0;
         commit_q <= 1'b0;
         caddr_q  <= '0;
         cdata_q  <= '0;
         io_out_q <= '0;
         oe_q     <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef QSPI_QUAD_EN
         quad_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         out_sr_q <= out_sr_d;
         ptr_q    <= ptr_d;
         rd_q     <= rd_d;
         fetch_q  <= fetch_d;
         commit_q <= commit_d;
         caddr_q  <= caddr_d;
         cdata_q  <= cdata_d;
         io_out_q <= io_out_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
`ifdef QSPI_QUAD_EN
         quad_q   <= quad_d;
`endif
      end
   end

   // Next-state, shift registers and registered SPI outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      out_sr_d   = out_sr_q;
      ptr_d      = ptr_q;
      rd_d       = rd_q;
      fetch_d    = 1'b0;
      commit_d   = 1'b0;
      caddr_d    = caddr_q;
      cdata_d    = cdata_q;
      io_out_d   = io_out_q;
      oe_d       = '0;
      err_d      = 1'b0;
      cmd_byte_c = {sr_q[6:0], io_s_q[0]};
`ifdef QSPI_QUAD_EN
      quad_d      = quad_q;
      addr_last_c = quad_q ? CW'(5) : CW'(23);
      byte_last_c = quad_q ? CW'(1) : CW'(7);
`else
      addr_last_c = CW'(23);
      byte_last_c = CW'(7);
`endif
      // Read byte is latched the clk after it is requested
      if (fetch_q) out_sr_d = mem[ptr_q];

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
`ifdef QSPI_QUAD_EN
            quad_d = 1'b0;
`endif
            if (!cs_s_q) state_d = S_CMD;
         end
         S_CMD: if (rise_c) begin
            sr_d  = cmd_byte_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(7)) begin
               cnt_d = '0;
               case (cmd_byte_c)
                  8'h03: begin state_d = S_ADDR; rd_d = 1'b1; end
                  8'h02: begin state_d = S_ADDR; rd_d = 1'b0; end
`ifdef QSPI_QUAD_EN
                  8'hEB: begin state_d = S_ADDR; rd_d = 1'b1; quad_d = 1'b1; end
                  8'h38: begin state_d = S_ADDR; rd_d = 1'b0; quad_d = 1'b1; end
`endif
                  default: begin state_d = S_IGNORE; err_d = 1'b1; end
               endcase
            end
         end
         S_ADDR: if (rise_c) begin
            // Shifting into an AW-bit pointer keeps the address modulo MEM_BYTES
`ifdef QSPI_QUAD_EN
            ptr_d = quad_q ? {ptr_q[AW-5:0], io_s_q} : {ptr_q[AW-2:0], io_s_q[0]};
`else
            ptr_d = {ptr_q[AW-2:0], io_s_q[0]};
`endif
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == addr_last_c) begin
               cnt_d = '0;
               if (!rd_q) begin
                  state_d = S_WDATA;
               end else begin
                  state_d = S_RDATA;
                  fetch_d = 1'b1;
               end
`ifdef QSPI_QUAD_EN
               if (rd_q && quad_q && (QUAD_WAIT_CYCLES != 0)) begin
                  state_d = S_WAIT;
                  fetch_d = 1'b0;
               end
`endif
            end
         end
`ifdef QSPI_QUAD_EN
         S_WAIT: if (rise_c) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(QUAD_WAIT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_RDATA;
               fetch_d = 1'b1;
            end
         end
`endif
         S_RDATA: begin
            if (fall_c) begin
`ifdef QSPI_QUAD_EN
               if (quad_q) begin
                  io_out_d = out_sr_q[7:4];
                  out_sr_d = {out_sr_q[3:0], 4'h0};
               end else begin
                  io_out_d = {2'b00, out_sr_q[7], 1'b0};
                  out_sr_d = {out_sr_q[6:0], 1'b0};
               end
`else
               io_out_d = {2'b00, out_sr_q[7], 1'b0};
               out_sr_d = {out_sr_q[6:0], 1'b0};
`endif
            end
            if (rise_c) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == byte_last_c) begin
                  cnt_d   = '0;
                  ptr_d   = ptr_q + AW'(1);
                  fetch_d = 1'b1;
               end
            end
         end
         S_WDATA: if (rise_c) begin
`ifdef QSPI_QUAD_EN
            sr_d = quad_q ? {sr_q[3:0], io_s_q} : {sr_q[6:0], io_s_q[0]};
`else
            sr_d = {sr_q[6:0], io_s_q[0]};
`endif
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == byte_last_c) begin
               cnt_d    = '0;
               commit_d = 1'b1;
               caddr_d  = ptr_q;
               cdata_d  = sr_d;
               ptr_d    = ptr_q + AW'(1);
            end
         end
         S_IGNORE: ;
         default: state_d = S_IDLE;
      endcase

      // CS high overrides everything; a pending commit is unaffected
      if (cs_s_q) state_d = S_IDLE;

      busy_d = (state_d != S_IDLE) && (state_d != S_IGNORE);
      if (state_d == S_RDATA) begin
`ifdef QSPI_QUAD_EN
         oe_d = quad_q ? 4'b1111 : 4'b0010;
`else
         oe_d = 4'b0010;
`endif
      end else begin
         io_out_d = '0;
      end
   end

   // Byte array: SPI commit has priority over the backdoor port
   always_ff @(posedge clk) begin
      if (commit_q) begin
         mem[caddr_q] <= cdata_q;
      end else if (init_we && !busy_q) begin
         mem[init_addr] <= init_data;
      end
   end

   assign spi_io_out = io_out_q;
   assign spi_io_oe  = oe_q;
   assign busy       = busy_q;
   assign err_cmd    = err_q;

endmodule

// File: doc/qspi_ram_responder.md
# qspi_ram_responder

Synthesizable SPI/QSPI RAM responder: the device end of the SoC's shared SPI memory interface. It decodes serial read/write commands from the memory controller's flash/PSRAM initiator and serves them from an on-chip byte array. It is used as a PSRAM stand-in on FPGA builds and as an in-bench device for SoC regressions. SPI signals are oversampled in the system clock domain. No second clock domain is introduced.

## Interface
- MEM_BYTES, 4096: size of the backing byte array; power of two.
- QUAD_WAIT_CYCLES, 6: dummy SCLK cycles between address and data for quad read.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- spi_cs_n  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock, mode 0.
- spi_io_in  in  4  IO lines from initiator; io[0]=MOSI in single mode.
- spi_io_out  out  4  IO lines to initiator; io[1]=MISO in single mode.
- spi_io_oe  out  4  per-line output enable.
- busy  out  1  high while a transaction is selected (CS low, not IGNORE).
- err_cmd  out  1  one-clk pulse on an unsupported command byte.
- init_we  in  1  backdoor byte write (preload), ignored while busy.
- init_addr  in  $clog2(MEM_BYTES)  backdoor address.
- init_data  in  8  backdoor data.

## Operation
- spi_cs_n, spi_sclk and spi_io_in pass through 2-flop synchronizers. SCLK rise/fall are detected from the synchronized value.
- Rising edges sample inputs. Falling edges update outputs. All data is MSB first.
- States:
  - IDLE: entered from any state when synchronized CS is high.
  - CMD: 8 bits on io[0].
  - ADDR: 24 bits. Single mode shifts on io[0]; quad shifts nibbles on io[3:0] over 6 SCLKs.
  - WAIT: quad read only, QUAD_WAIT_CYCLES SCLKs.
  - RDATA.
  - WDATA.
  - IGNORE: held until CS rises.
- Commands:
  - 0x03 read: single-mode address, then RDATA with no wait.
  - 0x02 write: single-mode address, then WDATA.
  - 0xEB quad read: quad address, WAIT, then RDATA in quad mode.
  - 0x38 quad write: quad address, then WDATA in quad mode.
  - Any other byte: err_cmd pulse, then IGNORE.
- The address is taken modulo MEM_BYTES; upper bits are ignored. The pointer increments per byte and wraps from MEM_BYTES-1 to 0.
- RDATA, single mode: oe=4'b0010, io_out[1] carries the bit.
- RDATA, quad mode: oe=4'b1111, upper nibble first.
- RDATA fetch: the byte at the pointer is latched in the clk cycle after the last address/wait rising edge, and again after each completed byte.
- WDATA: the byte commits to the array one clk after its 8th bit (2nd nibble) rising edge. A partial byte at CS rise is discarded.
- In all states other than RDATA: oe=0, io_out=0.

## Timing
- Reset values: spi_io_out=0, spi_io_oe=0, busy=0, err_cmd=0, state IDLE. Array contents are not reset.
- Clock ratio: spi_sclk must be ≤ clk/4, with each SCLK phase ≥2 clk.
- Input latency: 2 clk synchronizer plus 1 clk edge detect.
- Output timing: outputs change ≤3 clk after the SCLK falling edge, so data is valid well before the next rising edge.
- First read bit: for single read, bit 7 of the first byte is driven after the falling edge that follows the 24th address bit.
- CS deassert in any state: within 3 clk, oe=0, busy=0, state IDLE.
- Write commit:
  - A write committed before CS rise is kept.
  - A CS rise in the same clk as a pending commit still completes the commit.
- Backdoor writes:
  - init_we while busy=0 writes in 1 clk.
  - Simultaneous init_we and an SPI commit: SPI wins and init_we is dropped.
- rst asserted mid-transaction: immediate IDLE and outputs off. The initiator must reassert CS to start again.
- CS low with no SCLK: remains in CMD indefinitely.

## Configuration
- QSPI_QUAD_EN:
  - Defined: 0xEB and 0x38 are supported with the quad address, wait and data phases above.
  - Undefined: 0xEB and 0x38 are unsupported commands (err_cmd pulse, IGNORE). The quad shift logic and WAIT counter are not built, and spi_io_oe[3:2,0] are tied 0.

## Test plan
- Backdoor preload:
  - Stimulus: init_we writes 0xA5 at 0x010 and 0x3C at 0x011, then 0x03 read at addr 0x000010 for 2 bytes.
  - Required: MISO returns 0xA5, 0x3C; oe=4'b0010 only during data.
- Single write/read-back:
  - Stimulus: 0x02 at 0x000FFF writing 0x11, 0x22.
  - Required: wraps, so mem[0xFFF]=0x11 and mem[0x000]=0x22; a 0x03 read from 0xFFF returns the same pair.
- Quad read (QSPI_QUAD_EN):
  - Stimulus: 0xEB at 0x000010 with 6 dummy cycles.
  - Required: nibbles A,5,3,C; oe=4'b1111 only in data.
- Unsupported command:
  - Stimulus: 0x9F.
  - Required: one-clk err_cmd pulse; outputs off until CS high; a following 0x03 transaction works normally.
- CS abort mid-byte:
  - Stimulus: 0x02 at 0x020, first byte 0x77 complete, 4 bits of a second byte, then CS high.
  - Required: mem[0x020]=0x77, mem[0x021] unchanged, busy=0 within 3 clk.
- Reset mid-read:
  - Stimulus: rst asserted during RDATA.
  - Required: next clk has oe=0 and busy=0; a subsequent full transaction succeeds.
